sys_reg_burst_master: RTL and testbench
=======================================

Name: sys_reg_burst_master

Overview:
Bus initiator that programs and reads back system configuration/status registers in bursts. It accepts one burst command at a time, then issues single-beat requests to the register responder on a req/ack bus. Addresses auto-increment by one word per beat. Write data is pulled from an upstream stream; read data is pushed to a downstream stream.

Parameters:
DATA_WIDTH, 32, register data width in bits
ADDR_WIDTH, 16, word address width in bits
MAX_BURST, 256, maximum beats per burst; LEN_W = $clog2(MAX_BURST)
TIMEOUT, 64, cycles to wait for bus_ack before aborting; >=2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  accepting command (high only in IDLE)
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_WIDTH  start word address
cmd_len  in  LEN_W  beats minus one (0 -> 1 beat, MAX_BURST-1 -> MAX_BURST beats)
wr_valid  in  1  write data valid
wr_ready  out  1  write data accepted
wr_data  in  DATA_WIDTH  write data
rd_valid  out  1  read data valid
rd_ready  in  1  downstream accepts read data
rd_data  out  DATA_WIDTH  read data
rd_last  out  1  final beat of read burst
bus_req  out  1  request to responder
bus_we  out  1  request is write
bus_addr  out  ADDR_WIDTH  request address
bus_wdata  out  DATA_WIDTH  request write data
bus_ack  in  1  responder completes request this cycle
bus_rdata  in  DATA_WIDTH  read data, valid with bus_ack on reads
done  out  1  one-cycle pulse at burst end
err  out  1  one-cycle pulse with done when the burst aborted

Behaviour:
- Reset (async assert, sync deassert) drives all outputs to 0 and sets the state to IDLE. Exception: cmd_ready=1 once in IDLE. Counters and latched command are cleared.
- States: IDLE, FETCH, REQ, RDOUT, DONE.
- IDLE: cmd_ready=1. When cmd_valid&cmd_ready, latch write, addr, len, and set beat counter to 0.
  - Write command -> FETCH.
  - Read command -> REQ.
- FETCH: wr_ready=1. When wr_valid, register wr_data into bus_wdata -> REQ next cycle. Exactly one word is accepted per beat.
- REQ: bus_req=1, bus_we=latched write, bus_addr=start+beat (mod 2^ADDR_WIDTH; wrap is legal and silent).
  - Request signals hold stable until bus_ack.
  - bus_ack in the same cycle bus_req rises counts; minimum one cycle per beat.
  - On ack of a write: if beat==len -> DONE, else beat++ -> FETCH.
  - On ack of a read: capture bus_rdata -> RDOUT.
  - The timeout counter resets on entering REQ. If bus_ack has not arrived after TIMEOUT cycles with bus_req high: drop bus_req, set abort flag -> DONE. Remaining beats are skipped. A pending wr_data is not consumed further.
- RDOUT: rd_valid=1, rd_data stable, rd_last=(beat==len). On rd_ready:
  - if last -> DONE;
  - else beat++ -> REQ.
  - No new bus request is issued while read data is unaccepted.
- DONE: done=1 for one cycle; err=abort flag. Clear the flag -> IDLE.
- Command-to-first-bus_req latency:
  - read: 1 cycle after acceptance;
  - write: 1 cycle after the wr_valid handshake.
- The block never emits bus_req during IDLE, FETCH, RDOUT, or DONE.
- bus_ack outside REQ is ignored.
- Reset asserted mid-burst aborts immediately with no done pulse. The responder must tolerate bus_req dropping without ack.

Test Plan:
- Write cmd addr=0x0010 len=3, wr_data 0xA0..0xA3, bus_ack 1 cycle after each req -> bus_addr 0x10,0x11,0x12,0x13 with matching bus_wdata; exactly 4 wr handshakes; done=1, err=0.
- Read cmd addr=0x0200 len=0, bus_rdata=0xDEADBEEF, rd_ready held low 5 cycles -> rd_valid, rd_data and rd_last=1 stable for 5 cycles; no second bus_req; done after rd_ready.
- Read cmd addr=0xFFFE len=3 -> bus_addr 0xFFFE,0xFFFF,0x0000,0x0001; rd_last only on 4th beat.
- Write cmd len=255 with zero-wait ack -> 256 bus writes; beat counter does not overflow; single done pulse.
- Read cmd with bus_ack never asserted, TIMEOUT=64 -> bus_req high exactly 64 cycles then low; done=1 and err=1 same cycle; cmd_ready=1 next cycle.
- Reset pulse during REQ of beat 2 -> all outputs 0 asynchronously. After release cmd_ready=1 and a new command proceeds normally.

Source files
------------

// File: rtl/sys_reg_burst_master.sv
// Purpose : burst initiator for system config/status registers; one command at a
//           time, single-beat req/ack transfers with word-address auto-increment.
// Latency : first bus_req 1 cycle after read-command accept / write-data handshake.
// Backpr. : stalls in FETCH on wr_valid, in REQ on bus_ack (bounded by TIMEOUT),
//           in RDOUT on rd_ready; no new request while read data is unaccepted.
// Ports   : cmd_*  burst command in (valid/ready)
//           wr_*   write-data stream in (valid/ready)
//           rd_*   read-data stream out (valid/ready, rd_last on final beat)
//           bus_*  register responder req/ack bus
//           done/err  end-of-burst pulse, err set when the burst timed out
module sys_reg_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_BURST  = 256,
    parameter int TIMEOUT    = 64,
    localparam int LEN_W     = $clog2(MAX_BURST)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  done,
    output logic                  err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_RDOUT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            r_state;
    logic                  r_cmd_ready;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_beat;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_abort;
    logic [TW-1:0]         r_tcnt;

    logic [2:0]            w_nxt;
    logic                  w_last;
    logic                  w_tmo;

    assign w_last = (r_beat == r_len);
    // Last waiting cycle in REQ: an ack arriving in this same cycle still wins.
    assign w_tmo  = (r_tcnt == TW'(TIMEOUT - 1));

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid && r_cmd_ready) w_nxt = cmd_write ? S_FETCH : S_REQ;
            S_FETCH: if (wr_valid) w_nxt = S_REQ;
            S_REQ: begin
                if (bus_ack) begin
                    if (r_write) w_nxt = w_last ? S_DONE : S_FETCH;
                    else         w_nxt = S_RDOUT;
                end else if (w_tmo) begin
                    w_nxt = S_DONE;
                end
            end
            S_RDOUT: if (rd_ready) w_nxt = w_last ? S_DONE : S_REQ;
            S_DONE:  w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_abort     <= 1'b0;
            r_tcnt      <= '0;
        end else begin
            r_state     <= w_nxt;
            // Registered so cmd_ready stays low through reset and rises with IDLE.
            r_cmd_ready <= (w_nxt == S_IDLE);

            // Timeout counter only runs while a request is outstanding.
            if (r_state != S_REQ || bus_ack) r_tcnt <= '0;
            else                             r_tcnt <= r_tcnt + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_write <= cmd_write;
                        r_addr  <= cmd_addr;
                        r_len   <= cmd_len;
                        r_beat  <= '0;
                    end
                end
                S_FETCH: begin
                    if (wr_valid) r_wdata <= wr_data;
                end
                S_REQ: begin
                    if (bus_ack) begin
                        if (!r_write)    r_rdata <= bus_rdata;
                        else if (!w_last) r_beat <= r_beat + 1'b1;
                    end else if (w_tmo) begin
                        r_abort <= 1'b1;
                    end
                end
                S_RDOUT: begin
                    // Beat only advances when not last, so it never exceeds len.
                    if (rd_ready && !w_last) r_beat <= r_beat + 1'b1;
                end
                S_DONE: begin
                    r_abort <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign wr_ready  = (r_state == S_FETCH);
    assign bus_req   = (r_state == S_REQ);
    assign bus_we    = bus_req & r_write;
    // Word address wraps modulo 2^ADDR_WIDTH by plain truncation.
    assign bus_addr  = r_addr + ADDR_WIDTH'(r_beat);
    assign bus_wdata = r_wdata;
    assign rd_valid  = (r_state == S_RDOUT);
    assign rd_data   = r_rdata;
    assign rd_last   = rd_valid & w_last;
    assign done      = (r_state == S_DONE);
    assign err       = done & r_abort;

endmodule

// File: tb/tb_sys_reg_burst_master.sv
module tb_sys_reg_burst_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        bus_req, bus_we, bus_ack;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        done, err;

    always #5 clk = ~clk;

    sys_reg_burst_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .done(done), .err(err)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  len;
        bit          ack_en;
        int          ack_lat;
        int          rd_stall;
        logic [31:0] wr_base;
        logic [31:0] rdata_base;
        int          exp_beats;
        logic [15:0] exp_last;
        logic [31:0] exp_first;
        bit          exp_err;
        int          exp_req;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // environment knobs
    bit          ack_en, wr_en;
    int          ack_lat, rd_stall;
    logic [31:0] wr_base, rdata_base;

    // environment state / logs
    bit          pend, had_prev;
    int          rq_cnt, req_cycles, done_cnt, wr_idx, stall_cnt;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [15:0] q_addr[$];
    logic        q_we[$];
    logic [31:0] q_wd[$];
    logic [31:0] q_rd[$];
    logic        q_last[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Responder, write source and read sink, all acting on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0; bus_ack = 0; rd_ready = 0; had_prev = 0; stall_cnt = 0; wr_valid = 0;
        end else begin
            if (bus_req) begin
                if (pend) rq_cnt++; else rq_cnt = 0;
                req_cycles++;
                bus_ack = ack_en && (rq_cnt >= ack_lat);
                if (bus_ack) begin
                    bus_rdata = rdata_base + {16'h0, bus_addr};
                    q_addr.push_back(bus_addr);
                    q_we.push_back(bus_we);
                    q_wd.push_back(bus_wdata);
                end
                pend = !bus_ack;
            end else begin
                bus_ack = 0;
                pend = 0;
            end

            wr_valid = wr_en;
            wr_data  = wr_base + 32'(wr_idx);
            if (wr_valid && wr_ready) wr_idx++;

            if (rd_valid) begin
                if (had_prev) begin
                    chk("rd_hold_data", 64'(rd_data), 64'(prev_data));
                    chk("rd_hold_last", 64'(rd_last), 64'(prev_last));
                end
                rd_ready = (stall_cnt >= rd_stall);
                if (rd_ready) begin
                    q_rd.push_back(rd_data);
                    q_last.push_back(rd_last);
                    stall_cnt = 0;
                    had_prev = 0;
                end else begin
                    stall_cnt++;
                    prev_data = rd_data;
                    prev_last = rd_last;
                    had_prev = 1;
                end
            end else begin
                rd_ready = 0;
                had_prev = 0;
            end

            if (done) done_cnt++;
        end
    end

    task automatic clear_env(input vec_t v);
        ack_lat = v.ack_lat; ack_en = v.ack_en; rd_stall = v.rd_stall;
        rdata_base = v.rdata_base; wr_base = v.wr_base;
        q_addr.delete(); q_we.delete(); q_wd.delete(); q_rd.delete(); q_last.delete();
        req_cycles = 0; done_cnt = 0; wr_idx = 0; stall_cnt = 0;
    endtask

    task automatic send_cmd(input vec_t v, input string nm);
        int waited = 0;
        cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
        while (!cmd_ready && waited < 100) begin
            @(posedge clk); #1; waited++;
        end
        chk({nm, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic run_burst(input vec_t v, input string nm);
        bit seen = 0;
        logic [15:0] ea;
        clear_env(v);
        wr_en = v.wr;
        send_cmd(v, nm);
        for (int c = 0; c < 3000; c++) begin
            if (done) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        chk({nm, "_done_seen"}, 64'(seen), 64'(1));
        chk({nm, "_err"}, 64'(err), 64'(v.exp_err));
        @(posedge clk); #1;
        chk({nm, "_cmd_ready_after"}, 64'(cmd_ready), 64'(1));
        wr_en = 0;
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_done_cnt"}, 64'(done_cnt), 64'(1));
        chk({nm, "_req_cycles"}, 64'(req_cycles), 64'(v.exp_req));
        chk({nm, "_acks"}, 64'(q_addr.size()), 64'(v.exp_beats));
        if (v.wr) chk({nm, "_wr_hs"}, 64'(wr_idx), 64'(v.exp_beats));
        else      chk({nm, "_rd_hs"}, 64'(q_rd.size()), 64'(v.exp_beats));
        if (v.exp_beats > 0 && q_addr.size() == v.exp_beats) begin
            chk({nm, "_last_addr"}, 64'(q_addr[v.exp_beats-1]), 64'(v.exp_last));
            if (v.wr) chk({nm, "_first_wdata"}, 64'(q_wd[0]), 64'(v.exp_first));
            else if (q_rd.size() > 0) chk({nm, "_first_rdata"}, 64'(q_rd[0]), 64'(v.exp_first));
        end
        for (int i = 0; i < q_addr.size() && i < v.exp_beats; i++) begin
            ea = v.addr + 16'(i);
            chk($sformatf("%s_addr%0d", nm, i), 64'(q_addr[i]), 64'(ea));
            chk($sformatf("%s_we%0d", nm, i), 64'(q_we[i]), 64'(v.wr));
            if (v.wr) chk($sformatf("%s_wdata%0d", nm, i), 64'(q_wd[i]), 64'(v.wr_base + 32'(i)));
        end
        for (int i = 0; i < q_rd.size() && i < v.exp_beats; i++) begin
            ea = v.addr + 16'(i);
            chk($sformatf("%s_rdata%0d", nm, i), 64'(q_rd[i]), 64'(v.rdata_base + {16'h0, ea}));
            chk($sformatf("%s_rlast%0d", nm, i), 64'(q_last[i]), 64'(i == v.exp_beats - 1));
        end
    endtask

    initial begin
        vec_t vt[7];
        vec_t vrst, vpost;
        bit   reached;

        //        wr  addr      len     ack lat stall wr_base        rdata_base     beats last      first          err req
        vt[0] = '{1, 16'h0010, 8'd3,   1,  1,  0,    32'h000000A0, 32'h0,         4,   16'h0013, 32'h000000A0,  0,  8};
        vt[1] = '{0, 16'h0200, 8'd0,   1,  1,  5,    32'h0,        32'hDEADBCEF,  1,   16'h0200, 32'hDEADBEEF,  0,  2};
        vt[2] = '{0, 16'hFFFE, 8'd3,   1,  0,  0,    32'h0,        32'h12340000,  4,   16'h0001, 32'h1234FFFE,  0,  4};
        vt[3] = '{1, 16'h1000, 8'd255, 1,  0,  0,    32'h50000000, 32'h0,         256, 16'h10FF, 32'h50000000,  0,  256};
        vt[4] = '{0, 16'h0300, 8'd2,   0,  0,  0,    32'h0,        32'h0,         0,   16'h0000, 32'h0,         1,  64};
        vt[5] = '{0, 16'h0400, 8'd5,   1,  2,  2,    32'h0,        32'h0A000000,  6,   16'h0405, 32'h0A000400,  0,  18};
        vt[6] = '{1, 16'h7FFF, 8'd1,   1,  3,  0,    32'h000000C0, 32'h0,         2,   16'h8000, 32'h000000C0,  0,  8};
        vrst  = '{1, 16'h0050, 8'd5,   1,  2,  0,    32'h000000B0, 32'h0,         6,   16'h0055, 32'h000000B0,  0,  18};
        vpost = '{0, 16'h0060, 8'd1,   1,  1,  1,    32'h0,        32'h0,         2,   16'h0061, 32'h00000060,  0,  4};

        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        wr_valid = 0; wr_data = 0; rd_ready = 0; bus_ack = 0; bus_rdata = 0;
        ack_en = 0; wr_en = 0; ack_lat = 0; rd_stall = 0; wr_base = 0; rdata_base = 0;
        pend = 0; had_prev = 0; rq_cnt = 0; req_cycles = 0; done_cnt = 0; wr_idx = 0; stall_cnt = 0;
        prev_data = 0; prev_last = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_bus_req",   64'(bus_req),   64'(0));
        chk("rst_wr_ready",  64'(wr_ready),  64'(0));
        chk("rst_rd_valid",  64'(rd_valid),  64'(0));
        chk("rst_done",      64'(done),      64'(0));
        chk("rst_bus_addr",  64'(bus_addr),  64'(0));
        #2 rst_n = 1;
        @(posedge clk); #1;
        chk("rel_cmd_ready", 64'(cmd_ready), 64'(1));

        for (int k = 0; k < 7; k++) run_burst(vt[k], $sformatf("v%0d", k));

        // Reset while beat 2 of a write burst is on the bus.
        clear_env(vrst);
        wr_en = 1;
        send_cmd(vrst, "rstb");
        reached = 0;
        for (int c = 0; c < 200; c++) begin
            if (q_addr.size() == 2 && bus_req) begin reached = 1; break; end
            @(posedge clk); #1;
        end
        chk("rstb_reached_beat2", 64'(reached), 64'(1));
        chk("rstb_addr_beat2",    64'(bus_addr),  64'(16'h0052));
        chk("rstb_wdata_beat2",   64'(bus_wdata), 64'(32'hB2));
        #1 rst_n = 0;
        wr_en = 0;
        #1;
        chk("rstb_bus_req",   64'(bus_req),   64'(0));
        chk("rstb_bus_we",    64'(bus_we),    64'(0));
        chk("rstb_bus_addr",  64'(bus_addr),  64'(0));
        chk("rstb_bus_wdata", 64'(bus_wdata), 64'(0));
        chk("rstb_wr_ready",  64'(wr_ready),  64'(0));
        chk("rstb_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rstb_done",      64'(done),      64'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk); #1;
        chk("rstb_cmd_ready_rel", 64'(cmd_ready), 64'(1));
        chk("rstb_no_done",       64'(done_cnt),  64'(0));

        run_burst(vpost, "post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
